// File: rtl/hb_pkg.sv
`default_nettype none
// ============================================================================
//  Package : hb_pkg
//  Shared constants, coefficients and helpers for the second halfband stage.
//  Revision: 1.0
// ============================================================================
package hb_pkg;

    localparam int WIDTH    = 18;
    localparam int LENGTH   = 11;
    localparam int NPAIR    = 3;
    localparam int CNTW     = 4;
    // Coefficients carry one extra bit so the centre tap can hold +2^17 exactly
    localparam int CW       = WIDTH + 1;
    localparam int PROD_MSB = 34;
    localparam int PROD_LSB = 17;
    localparam int GW       = WIDTH + 2;
    localparam int SAT_MAX  = 131071;
    localparam int SAT_MIN  = -131072;

    localparam logic signed [CW-1:0] H0 = 19'sd3081;
    localparam logic signed [CW-1:0] H2 = -19'sd19040;
    localparam logic signed [CW-1:0] H4 = 19'sd81495;
    localparam logic signed [CW-1:0] HC = 19'sd131072;

    localparam logic [CNTW-1:0] C_LEN_CNT = CNTW'(LENGTH);

    typedef logic signed [WIDTH-1:0] sample_t;

    function automatic logic signed [CW-1:0] pair_coeff(input int k);
        case (k)
            0:       return H0;
            1:       return H2;
            default: return H4;
        endcase
    endfunction

    function automatic sample_t sat_clip(input logic signed [GW-1:0] v);
        if (v > GW'(SAT_MAX))
            return sample_t'(SAT_MAX);
        else if (v < GW'(SAT_MIN))
            return sample_t'(SAT_MIN);
        else
            return sample_t'(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hb_preadd_mult.sv
`default_nettype none
// ============================================================================
//  Module  : hb_preadd_mult
//  Registered symmetric pre-add followed by a registered multiply and slice.
//  Revision: 1.0
// ============================================================================
module hb_preadd_mult
    import hb_pkg::*;
#(
    parameter logic signed [CW-1:0] COEFF = '0
)(
    input  logic    clk,
    input  logic    reset,
    input  sample_t i_a,
    input  sample_t i_b,
    output sample_t o_m
);

    logic signed [CW-1:0]   r_p;
    sample_t                r_m;
    logic signed [2*CW-1:0] w_pe;
    logic signed [2*CW-1:0] w_ce;
    logic signed [2*CW-1:0] w_prod;
    logic [2*CW-1-PROD_MSB+PROD_LSB-1:0] w_drop_unused;

    assign w_pe   = {{CW{r_p[CW-1]}}, r_p};
    assign w_ce   = {{CW{COEFF[CW-1]}}, COEFF};
    assign w_prod = w_pe * w_ce;
    // Bits outside the 1s17 window carry no information for in-range data
    assign w_drop_unused = {w_prod[2*CW-1:PROD_MSB+1], w_prod[PROD_LSB-1:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_p <= '0;
            r_m <= '0;
        end else begin
            r_p <= {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};
            r_m <= w_prod[PROD_MSB:PROD_LSB];
        end
    end

    assign o_m = r_m;

endmodule
`default_nettype wire

// File: rtl/halfband_2nd_decim.sv
`default_nettype none
// ============================================================================
//  Module  : halfband_2nd_decim
//  11-tap halfband, 2:1 decimation, pipelined with warm-up gated valid.
//  Option  : HB2_SAT_EN -> guard-bit sums with clipped final output.
//  Revision: 1.0
// ============================================================================
module halfband_2nd_decim
    import hb_pkg::*;
(
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    sys_clk2_en,
    input  logic                    sam_clk_en,
    input  logic signed [WIDTH-1:0] x_in,
    output logic signed [WIDTH-1:0] y,
    output logic                    y_valid
);

`ifdef HB2_SAT_EN
    localparam int SW = GW;
`else
    localparam int SW = WIDTH;
`endif

    sample_t             r_x [LENGTH];
    logic [CNTW-1:0]     r_count;
    logic [CNTW-1:0]     w_count_nxt;
    logic                w_launch;
    logic                w_warm;
    logic [3:0]          r_tag;
    logic [3:0]          r_vld;
    sample_t             w_m [NPAIR];
    sample_t             w_mc;
    logic signed [SW-1:0] w_s0;
    logic signed [SW-1:0] w_s1;
    logic signed [SW-1:0] r_s0;
    logic signed [SW-1:0] r_s1;
    logic signed [SW-1:0] w_sum;
    sample_t             w_y;
    logic                w_lsb_unused;

    assign w_lsb_unused = x_in[0];
    assign w_count_nxt  = (r_count == C_LEN_CNT) ? r_count : r_count + CNTW'(1);
    assign w_launch     = sys_clk2_en & sam_clk_en;
    assign w_warm       = (w_count_nxt == C_LEN_CNT);

    // Delay line holds samples pre-halved to 2s16 so pair sums fit WIDTH+1
    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            for (int i = 0; i < LENGTH; i++)
                r_x[i] <= '0;
            r_count <= '0;
        end else if (sys_clk2_en) begin
            r_x[0] <= {x_in[WIDTH-1], x_in[WIDTH-1:1]};
            for (int i = 1; i < LENGTH; i++)
                r_x[i] <= r_x[i-1];
            r_count <= w_count_nxt;
        end
    end

    for (genvar k = 0; k < NPAIR; k++) begin : g_pair
        hb_preadd_mult #(
            .COEFF (pair_coeff(k))
        ) u_pm (
            .clk   (sys_clk),
            .reset (reset),
            .i_a   (r_x[2*k]),
            .i_b   (r_x[LENGTH-1-2*k]),
            .o_m   (w_m[k])
        );
    end

    hb_preadd_mult #(
        .COEFF (HC)
    ) u_centre (
        .clk   (sys_clk),
        .reset (reset),
        .i_a   (r_x[(LENGTH-1)/2]),
        .i_b   ('0),
        .o_m   (w_mc)
    );

    assign w_s0  = SW'(w_m[0]) + SW'(w_m[1]);
    assign w_s1  = SW'(w_m[2]) + SW'(w_mc);
    assign w_sum = r_s0 + r_s1;

`ifdef HB2_SAT_EN
    assign w_y = sat_clip(w_sum);
`else
    assign w_y = w_sum;
`endif

    // Tags run alongside data: stage 3 lines up with the level-1 sums
    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            r_tag   <= '0;
            r_vld   <= '0;
            r_s0    <= '0;
            r_s1    <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            r_tag   <= {r_tag[2:0], w_launch};
            r_vld   <= {r_vld[2:0], w_launch & w_warm};
            r_s0    <= w_s0;
            r_s1    <= w_s1;
            if (r_tag[3])
                y <= w_y;
            y_valid <= r_vld[3];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_halfband_2nd_decim.sv
`default_nettype none
// ============================================================================
//  Module  : tb_halfband_2nd_decim
//  Randomised self-checking bench for halfband_2nd_decim with an arithmetic model.
//  Revision: 1.0
// ============================================================================
module tb_halfband_2nd_decim;

    logic               sys_clk = 1'b0;
    logic               reset = 1'b0;
    logic               sys_clk2_en = 1'b0;
    logic               sam_clk_en = 1'b0;
    logic signed [17:0] x_in = '0;
    logic signed [17:0] y;
    logic               y_valid;

    halfband_2nd_decim dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .sys_clk2_en (sys_clk2_en),
        .sam_clk_en  (sam_clk_en),
        .x_in        (x_in),
        .y           (y),
        .y_valid     (y_valid)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: accepted-sample history and scheduled results
    typedef struct {
        int due;
        int yv;
        bit v;
    } ev_t;
    int  hist [11];
    int  n_acc = 0;
    int  exp_y = 0;
    bit  exp_v = 1'b0;
    bit  exp_upd = 1'b0;
    ev_t pend [$];

    function automatic longint coef(input int k);
        case (k)
            0:       return 3081;
            1:       return -19040;
            default: return 81495;
        endcase
    endfunction

    function automatic int wrap18(input longint v);
        logic signed [17:0] t;
        t = v[17:0];
        return int'(t);
    endfunction

    // y = sum_k Hk*(x[2k]+x[10-2k]) + HC*x[5], each product floored to 1s17
    function automatic int model_y();
        longint m [4];
        longint s;
        for (int k = 0; k < 3; k++)
            m[k] = (coef(k) * longint'(hist[2*k] + hist[10-2*k])) >>> 17;
        m[3] = (longint'(131072) * longint'(hist[5])) >>> 17;
`ifdef HB2_SAT_EN
        s = m[0] + m[1] + m[2] + m[3];
        if (s > 131071)  s = 131071;
        if (s < -131072) s = -131072;
        return int'(s);
`else
        s = longint'(wrap18(m[0] + m[1])) + longint'(wrap18(m[2] + m[3]));
        return wrap18(s);
`endif
    endfunction

    task automatic tick(input bit rn, input bit en, input bit sm, input logic signed [17:0] xi);
        ev_t e;
        reset       = rn;
        sys_clk2_en = en;
        sam_clk_en  = sm;
        x_in        = xi;
        @(posedge sys_clk);
        cyc++;
        exp_upd = 1'b0;
        exp_v   = 1'b0;
        if (!rn) begin
            for (int i = 0; i < 11; i++) hist[i] = 0;
            n_acc = 0;
            pend.delete();
            exp_y = 0;
        end else begin
            while (pend.size() > 0 && pend[0].due == cyc) begin
                exp_y   = pend[0].yv;
                exp_v   = pend[0].v;
                exp_upd = 1'b1;
                void'(pend.pop_front());
            end
            if (en) begin
                for (int i = 10; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = int'(xi) >>> 1;
                if (n_acc < 11) n_acc++;
                if (sm) begin
                    e.due = cyc + 4;
                    e.yv  = model_y();
                    e.v   = (n_acc == 11);
                    pend.push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 18'sd0);
        tick(1'b0, 1'b0, 1'b0, 18'sd0);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 18'($urandom));
            n_checks++;
            if (y !== 18'sd0 || y_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset: cyc=%0d y=%0d y_valid=%0b, required y=0 y_valid=0", cyc, y, y_valid);
            end
        end
    endtask

    task automatic test_dc();
        int pulses;
        bit en, sm, p;
        pulses = 0;
        p = 1'b0;
        do_reset();
        for (int c = 0; c < 86; c++) begin
            en = (c % 2 == 0) && (c < 80);
            sm = en & p;
            if (en) p = ~p;
            tick(1'b1, en, sm, 18'sd65536);
            n_checks++;
            if (y !== exp_y || y_valid !== exp_v) begin
                n_fail++;
                $display("FAIL dc_model: cyc=%0d y=%0d y_valid=%0b, required y=%0d y_valid=%0b", cyc, y, y_valid, exp_y, exp_v);
            end
            if (y_valid) begin
                pulses++;
                n_checks++;
                if (y < 65535 || y > 65537) begin
                    n_fail++;
                    $display("FAIL dc_gain: cyc=%0d y=%0d, required 65536+-1", cyc, y);
                end
            end
        end
        n_checks++;
        if (pulses != 15) begin
            n_fail++;
            $display("FAIL dc_pulses: got %0d y_valid pulses, required 15", pulses);
        end
    endtask

    task automatic test_latency();
        int first_launch, first_valid, s;
        bit en, sm;
        first_launch = -1;
        first_valid  = -1;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            en = (c % 2 == 0);
            s  = c / 2 + 1;
            sm = en && (s % 2 == 1);
            tick(1'b1, en, sm, 18'($urandom));
            if (en && sm && s >= 11 && first_launch < 0) first_launch = cyc;
            if (y_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            n_checks++;
            if (y !== exp_y || y_valid !== exp_v) begin
                n_fail++;
                $display("FAIL latency_model: cyc=%0d y=%0d y_valid=%0b, required y=%0d y_valid=%0b", cyc, y, y_valid, exp_y, exp_v);
            end
        end
        n_checks++;
        if (first_launch < 0 || first_valid != first_launch + 4) begin
            n_fail++;
            $display("FAIL latency_first_valid: first y_valid at cyc %0d, required cyc %0d", first_valid, first_launch + 4);
        end
    endtask

    task automatic test_impulse(input bit even_phase);
        int got [$];
        int want [8];
        int s, v, imp_s;
        bit en, sm;
        if (even_phase) want = '{770, -4760, 20373, 20373, -4760, 770, 0, 0};
        else            want = '{0, 0, 32768, 0, 0, 0, 0, 0};
        imp_s = even_phase ? 2 : 1;
        do_reset();
        for (int c = 0; c < 38; c++) begin
            en = (c % 2 == 0) && (c < 32);
            s  = c / 2 + 1;
            sm = en && (s % 2 == 0);
            tick(1'b1, en, sm, (en && s == imp_s) ? 18'sd65536 : 18'sd0);
            if (exp_upd) got.push_back(int'(y));
        end
        n_checks++;
        if (got.size() != 8) begin
            n_fail++;
            $display("FAIL impulse_count(even=%0b): got %0d outputs, required 8", even_phase, got.size());
        end
        for (int i = 0; i < 8; i++) begin
            v = (i < got.size()) ? got[i] : 999999;
            n_checks++;
            if (v != want[i]) begin
                n_fail++;
                $display("FAIL impulse(even=%0b) out%0d: y=%0d, required %0d", even_phase, i, v, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 45; c++) begin
            tick(1'b1, c < 40, c < 40, 18'($urandom));
            n_checks++;
            if (y !== exp_y || y_valid !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back: cyc=%0d y=%0d y_valid=%0b, required y=%0d y_valid=%0b", cyc, y, y_valid, exp_y, exp_v);
            end
        end
    endtask

    task automatic test_stress();
        logic signed [17:0] xi;
        do_reset();
        for (int c = 0; c < 105; c++) begin
            if (c < 40)      xi = (c % 2 == 1) ? 18'sh20000 : 18'sh1FFFF;
            else             xi = ($urandom_range(0, 1) == 1) ? 18'sh20000 : 18'sh1FFFF;
            tick(1'b1, c < 100, (c < 40) ? (c % 2 == 1) : 1'($urandom_range(0, 1)), xi);
            n_checks++;
            if (y !== exp_y || y_valid !== exp_v) begin
                n_fail++;
                $display("FAIL stress: cyc=%0d y=%0d y_valid=%0b, required y=%0d y_valid=%0b", cyc, y, y_valid, exp_y, exp_v);
            end
        end
    endtask

    task automatic test_random();
        bit rn;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            rn = ($urandom_range(0, 99) != 0);
            tick(rn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 18'($urandom));
            n_checks++;
            if (y !== exp_y || y_valid !== exp_v) begin
                n_fail++;
                $display("FAIL random: cyc=%0d y=%0d y_valid=%0b, required y=%0d y_valid=%0b", cyc, y, y_valid, exp_y, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dc();
        test_latency();
        test_impulse(1'b1);
        test_impulse(1'b0);
        test_back_to_back();
        test_stress();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
